// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO read-side blocks.
// Imported by fifo_rd_stream.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    FULL
  } rd_buf_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// FIFO read drain: 2-entry skid buffer turning r_empty/r_en/r_data
// into a registered valid/ready stream with m_last every PKT_LEN beats.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int PKT_LEN   = 16
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic                 r_empty,
  input  logic [DATA_SIZE-1:0] r_data,
  output logic                 r_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_last,
  output logic                 idle
);

  localparam int CW = clog2_min1(PKT_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN - 1);

  rd_buf_state_t        r_state;
  rd_buf_state_t        w_next;
  logic [DATA_SIZE-1:0] r_out;
  logic [DATA_SIZE-1:0] r_skid;
  logic [CW-1:0]        r_beat_cnt;

  logic w_fetch;
  logic w_pop;
  logic w_ld_out;
  logic w_ld_skid;
  logic w_sel_skid;

  // Pop never depends on m_ready, so no comb path m_ready -> r_en.
  assign w_fetch = r_rst_n && !r_empty && (r_state != FULL);
  assign w_pop   = m_valid && m_ready;

  assign r_en    = w_fetch;
  assign m_valid = (r_state != EMPTY);
  assign m_data  = r_out;
  assign m_last  = m_valid && (r_beat_cnt == LAST_CNT);
  assign idle    = (r_state == EMPTY) && r_empty;

  always_comb begin
    w_next     = r_state;
    w_ld_out   = 1'b0;
    w_ld_skid  = 1'b0;
    w_sel_skid = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_fetch) begin
          w_ld_out = 1'b1;
          w_next   = HALF;
        end
      end
      HALF: begin
        unique case ({w_fetch, w_pop})
          2'b11: w_ld_out = 1'b1;
          2'b10: begin
            w_ld_skid = 1'b1;
            w_next    = FULL;
          end
          2'b01: w_next = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        if (w_pop) begin
          w_ld_out   = 1'b1;
          w_sel_skid = 1'b1;
          w_next     = HALF;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state <= EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      if (w_ld_out)
        r_out <= w_sel_skid ? r_skid : r_data;
      if (w_ld_skid)
        r_skid <= r_data;
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= m_last ? '0 : r_beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO and stream reference model,
// two DUTs (PKT_LEN 16 and 4) sharing the same FIFO and ready inputs.
module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rst_cmd = 1'b0;
  logic          r_empty = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] r_data = '0;

  logic          ren_a, mv_a, ml_a, idle_a;
  logic          ren_b, mv_b, ml_b, idle_b;
  logic [DW-1:0] md_a, md_b;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_SIZE(DW), .PKT_LEN(16)) u16 (
    .r_clk(clk), .r_rst_n(rst_n), .r_empty(r_empty),
    .r_data(r_data), .r_en(ren_a), .m_valid(mv_a),
    .m_ready(m_ready), .m_data(md_a), .m_last(ml_a),
    .idle(idle_a)
  );

  fifo_rd_stream #(.DATA_SIZE(DW), .PKT_LEN(4)) u4 (
    .r_clk(clk), .r_rst_n(rst_n), .r_empty(r_empty),
    .r_data(r_data), .r_en(ren_b), .m_valid(mv_b),
    .m_ready(m_ready), .m_data(md_b), .m_last(ml_b),
    .idle(idle_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int npop    = 0;
  int n_fetch = 0;
  int n_pops  = 0;
  int rdy_pct = 100;
  int pushed  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check before posedge, advance model.
  task automatic step();
    logic fetch;
    logic pop;
    logic ev;
    @(negedge clk);
    if (!rst_cmd && rst_n) begin
      fq.delete();
      sb.delete();
      npop = 0;
    end
    rst_n   = rst_cmd;
    r_empty = (fq.size() == 0);
    r_data  = r_empty ? '0 : fq[0];
    m_ready = ($urandom_range(99) < rdy_pct);
    #1;
    ev    = (sb.size() != 0);
    fetch = rst_n && !r_empty && (sb.size() < 2);
    pop   = ev && m_ready;
    chk("r_en16", 32'(ren_a), 32'(fetch));
    chk("r_en4", 32'(ren_b), 32'(fetch));
    chk("valid16", 32'(mv_a), 32'(ev));
    chk("valid4", 32'(mv_b), 32'(ev));
    if (ev) begin
      chk("data16", 32'(md_a), 32'(sb[0]));
      chk("data4", 32'(md_b), 32'(sb[0]));
    end
    chk("last16", 32'(ml_a), 32'(ev && (npop % 16 == 15)));
    chk("last4", 32'(ml_b), 32'(ev && (npop % 4 == 3)));
    chk("idle16", 32'(idle_a), 32'(!ev && r_empty));
    chk("idle4", 32'(idle_b), 32'(!ev && r_empty));
    @(posedge clk);
    if (rst_n) begin
      if (pop) begin
        void'(sb.pop_front());
        npop++;
        n_pops++;
      end
      if (fetch) begin
        sb.push_back(fq.pop_front());
        n_fetch++;
      end
    end
  endtask

  task automatic pulse_reset();
    rst_cmd = 1'b0;
    step();
    step();
    rst_cmd = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset held with a non-empty FIFO
    fq = '{8'h11, 8'h22, 8'h33};
    rdy_pct = 0;
    repeat (3) step();
    chk("rst_data16", 32'(md_a), 32'h0);
    chk("rst_data4", 32'(md_b), 32'h0);
    chk("rst_valid", 32'(mv_a), 32'h0);
    chk("rst_last", 32'(ml_a | ml_b), 32'h0);
    n_fetch = 0;
    rst_cmd = 1'b1;
    step();
    chk("rel_fetch", n_fetch, 1);
    step();
    chk("rel_valid", 32'(mv_a), 32'h1);
    rdy_pct = 100;
    repeat (6) step();

    // Full-rate streaming of 0x00..0x1F
    pulse_reset();
    for (int i = 0; i < 32; i++) fq.push_back(DW'(i));
    rdy_pct = 100;
    n_pops  = 0;
    repeat (33) step();
    chk("stream_beats", n_pops, 32);
    repeat (2) step();

    // Backpressure: only two words fetched
    pulse_reset();
    fq = '{8'hA1, 8'hA2, 8'hA3};
    rdy_pct = 0;
    n_fetch = 0;
    repeat (6) step();
    chk("bp_fetches", n_fetch, 2);
    chk("bp_hold", 32'(md_a), 32'hA1);
    rdy_pct = 100;
    n_pops  = 0;
    repeat (3) step();
    chk("bp_drain", n_pops, 3);
    repeat (2) step();

    // FIFO empties mid-packet, resumes after a gap
    pulse_reset();
    for (int i = 0; i < 6; i++) fq.push_back(DW'(8'h40 + i));
    rdy_pct = 100;
    repeat (10) step();
    repeat (20) step();
    chk("gap_idle", 32'(idle_b), 32'h1);
    fq.push_back(8'h46);
    fq.push_back(8'h47);
    repeat (5) step();
    chk("gap_beats", npop, 8);

    // Asynchronous reset while FULL mid-packet
    pulse_reset();
    for (int i = 0; i < 8; i++) fq.push_back(DW'(8'h60 + i));
    rdy_pct = 100;
    repeat (3) step();
    rdy_pct = 0;
    repeat (3) step();
    chk("mid_full", sb.size(), 2);
    rst_cmd = 1'b0;
    step();
    chk("mid_async", 32'(mv_a | mv_b), 32'h0);
    rst_cmd = 1'b1;
    for (int i = 0; i < 4; i++) fq.push_back(DW'(8'h70 + i));
    rdy_pct = 100;
    repeat (6) step();

    // Random fill and random ready over 1000 words
    pulse_reset();
    rdy_pct = 50;
    pushed  = 0;
    n_pops  = 0;
    for (int c = 0; c < 20000; c++) begin
      if (pushed >= 1000 && fq.size() == 0 && sb.size() == 0) break;
      if (pushed < 1000 && $urandom_range(2) == 0) begin
        int burst;
        burst = int'($urandom_range(1, 4));
        for (int k = 0; k < burst && pushed < 1000; k++) begin
          fq.push_back(DW'($urandom));
          pushed++;
        end
      end
      step();
    end
    chk("rand_count", n_pops, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
